// File: rtl/y86_dmem_responder.sv
// Y86-64 data memory responder.
// Single-outstanding request/response memory with a fixed response latency.
// Optional build macro Y86_DMEM_ALIGN_CHECK_EN: when defined, a request whose
// req_addr[2:0] is non-zero also faults. When it is undefined, the low address
// bits are ignored.
module y86_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // WAIT counts down from LATENCY-2 so RESP is entered LATENCY edges after accept.
    localparam logic [3:0] CntLoad = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [63:0] rdata_q, rdata_d;

    logic [63:0] mem_q [DEPTH_WORDS];

    logic [60:0]   word_idx;
    logic [AW-1:0] mem_idx;
    logic          range_fault;
    logic          align_fault;
    logic          fault;
    logic          mem_we;

    // Decode the word index and fault conditions for the presented request.
    always_comb begin
        word_idx    = req_addr[63:3];
        mem_idx     = word_idx[AW-1:0];
        // Every upper address bit takes part in the range check.
        range_fault = ({3'b000, word_idx} >= 64'(DEPTH_WORDS));
`ifdef Y86_DMEM_ALIGN_CHECK_EN
        align_fault = (req_addr[2:0] != 3'b000);
`else
        align_fault = 1'b0;
`endif
        fault       = range_fault | align_fault;
    end

`ifndef Y86_DMEM_ALIGN_CHECK_EN
    logic unused_addr_lo;
    assign unused_addr_lo = ^req_addr[2:0];
`endif

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP until taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    err_d   = fault;
                    // Read data is captured at accept; writes and faults return zero.
                    rdata_d = (!req_we && !fault) ? mem_q[mem_idx] : 64'd0;
                    mem_we  = req_we && !fault;
                    if (LATENCY <= 1) begin
                        state_d = StResp;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    we_d    = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = 64'd0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory array: never cleared by reset; a write on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_idx] <= req_wdata;
        end
    end

    // Outputs are functions of state only; response fields read zero outside RESP.
    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        rsp_error = rsp_valid & err_q;
        rsp_rdata = (rsp_valid && !we_q && !err_q) ? rdata_q : 64'd0;
    end

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Bench for y86_dmem_responder: directed checks with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_y86_dmem_responder #(
    parameter int unsigned TbLatency = 2
);

    localparam int unsigned LAT = TbLatency;
    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_error;

    int n_cmp = 0;
    int n_bad = 0;

    y86_dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [63:0] mmem   [DEPTH];
    bit          mknown [DEPTH];
    bit          busy = 1'b0;
    int          age = 0;        // edges since accept, accept edge counts as 1
    logic [63:0] exp_d = '0;
    bit          exp_e = 1'b0;
    bit          exp_dknown = 1'b0;
    bit          chk_en = 1'b0;

    function automatic bit model_fault(input logic [63:0] a);
        bit f;
        f = ((a >> 3) >= 64'(DEPTH));
`ifdef Y86_DMEM_ALIGN_CHECK_EN
        if (a[2:0] != 3'b000) f = 1'b1;
`endif
        return f;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            busy = 1'b0;
            age  = 0;
        end else if (!busy) begin
            if (req_valid) begin
                int idx;
                busy = 1'b1;
                age  = 1;
                idx  = int'(req_addr >> 3);
                if (model_fault(req_addr)) begin
                    exp_e = 1'b1; exp_d = '0; exp_dknown = 1'b1;
                end else if (req_we) begin
                    mmem[idx] = req_wdata; mknown[idx] = 1'b1;
                    exp_e = 1'b0; exp_d = '0; exp_dknown = 1'b1;
                end else begin
                    exp_e = 1'b0; exp_d = mmem[idx]; exp_dknown = mknown[idx];
                end
            end
        end else if (age >= int'(LAT)) begin
            if (rsp_ready) busy = 1'b0;
        end else begin
            age++;
        end
    end

    // Per-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit ev;
            ev = busy && (age >= int'(LAT));
            chk("req_ready", 64'(req_ready), 64'(!busy));
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            chk("rsp_error", 64'(rsp_error), 64'(ev && exp_e));
            if (!ev || exp_dknown)
                chk("rsp_rdata", rsp_rdata, ev ? exp_d : 64'd0);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output int lat);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata; er = rsp_error;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    function automatic logic [63:0] rand_addr();
        int unsigned k;
        logic [63:0] a;
        k = $urandom_range(0, 9);
        if (k <= 5)      a = 64'($urandom_range(0, 15)) << 3;
        else if (k == 6) a = 64'($urandom_range(DEPTH - 2, DEPTH + 1)) << 3;
        else if (k == 7) a = {$urandom, $urandom};
        else if (k == 8) a = 64'h1 << $urandom_range(11, 63);
        else             a = (64'($urandom_range(0, 15)) << 3) | 64'($urandom_range(0, 7));
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);
        chk("reset_rsp_error", 64'(rsp_error), 64'd0);
        chk_en = 1'b1;

        // Write then read back word 0x40.
        txn(1'b1, 64'h40, 64'h1122334455667788, rd, er, lat);
        chk("wr40_latency", 64'(lat), 64'(LAT));
        chk("wr40_error", 64'(er), 64'd0);
        chk("wr40_rdata", rd, 64'd0);
        txn(1'b0, 64'h40, 64'd0, rd, er, lat);
        chk("rd40_latency", 64'(lat), 64'(LAT));
        chk("rd40_rdata", rd, 64'h1122334455667788);
        chk("rd40_error", 64'(er), 64'd0);

        // Out-of-range accesses fault and must not alias onto word 0.
        txn(1'b1, 64'h0, 64'h000000000000dead, rd, er, lat);
        txn(1'b0, 64'h800, 64'd0, rd, er, lat);
        chk("rd800_error", 64'(er), 64'd1);
        chk("rd800_rdata", rd, 64'd0);
        txn(1'b1, 64'h800, 64'hffffffffffffffff, rd, er, lat);
        chk("wr800_error", 64'(er), 64'd1);
        txn(1'b0, 64'h0, 64'd0, rd, er, lat);
        chk("rd0_after_wr800", rd, 64'h000000000000dead);
        txn(1'b0, 64'h8000000000000000, 64'd0, rd, er, lat);
        chk("rd_msb_error", 64'(er), 64'd1);

        // Back-pressure: response held while rsp_ready stays low.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h40; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rdata", rsp_rdata, 64'h1122334455667788);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("release_req_ready", 64'(req_ready), 64'd1);
        chk("release_rsp_valid", 64'(rsp_valid), 64'd0);

        // Reset mid-transaction keeps the already-committed write.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h10; req_wdata = 64'hAA;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        txn(1'b0, 64'h10, 64'd0, rd, er, lat);
        chk("rd10_after_rst", rd, 64'hAA);

        // A request on a reset edge is dropped.
        txn(1'b1, 64'h18, 64'h77, rd, er, lat);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h18; req_wdata = 64'h55; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        chk("rstreq_req_ready", 64'(req_ready), 64'd1);
        txn(1'b0, 64'h18, 64'd0, rd, er, lat);
        chk("rd18_after_rstreq", rd, 64'h77);

        // Misaligned read.
        txn(1'b0, 64'h43, 64'd0, rd, er, lat);
`ifdef Y86_DMEM_ALIGN_CHECK_EN
        chk("rd43_error", 64'(er), 64'd1);
        chk("rd43_rdata", rd, 64'd0);
`else
        chk("rd43_error", 64'(er), 64'd0);
        chk("rd43_rdata", rd, 64'h1122334455667788);
`endif

        // Random traffic; the per-cycle checker does the comparing.
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 99) < 2);
            req_valid = ($urandom_range(0, 99) < 45);
            req_we    = $urandom_range(0, 1) != 0;
            req_addr  = rand_addr();
            req_wdata = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 99) < 50);
            @(negedge clk);
        end
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        chk("final_req_ready", 64'(req_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
